// File: rtl/key_entry_ctrl_if.sv
// Keypad entry bus: scanner level input, entry buffer view,
// action pulses and committed-value valid/ready handshake.
interface key_entry_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_data;
    logic [23:0] show_data;
    logic [2:0]  digit_cnt;
    logic        beep_req;
    logic        err;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ready;

    modport master (
        output key_valid,
        output key_data,
        output out_ready,
        input  show_data,
        input  digit_cnt,
        input  beep_req,
        input  err,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  key_valid,
        input  key_data,
        input  out_ready,
        output show_data,
        output digit_cnt,
        output beep_req,
        output err,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: press detection with release lockout,
// six-digit entry buffer, and committed-value output handshake.
module key_entry_ctrl #(
    parameter int unsigned RELEASE_CYC = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    key_entry_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE,
        WAIT_REL
    } state_t;

    localparam logic [15:0] REL_LAST = 16'(RELEASE_CYC - 1);

    state_t      state_q, state_d;
    logic        kv_q, kv_qq;
    logic [3:0]  kd_q;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [23:0] show_q, show_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        beep_q, beep_d;
    logic        err_q, err_d;
    logic        ov_q, ov_d;
    logic [23:0] od_q, od_d;
    logic        press;

    assign press = kv_q & ~kv_qq & (state_q == IDLE);

    // Next-state: release lockout counter, key decode, handshake
    always_comb begin
        state_d   = state_q;
        low_cnt_d = low_cnt_q;
        show_d    = show_q;
        cnt_d     = cnt_q;
        beep_d    = 1'b0;
        err_d     = 1'b0;
        ov_d      = ov_q;
        od_d      = od_q;

        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = WAIT_REL;
                    if (kd_q <= 4'h9) begin
                        if (cnt_q != 3'd6) begin
                            show_d = {show_q[19:0], kd_q};
                            cnt_d  = cnt_q + 3'd1;
                            beep_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (kd_q == 4'hA) begin
                        if (cnt_q != 3'd0) begin
                            show_d = {4'h0, show_q[23:4]};
                            cnt_d  = cnt_q - 3'd1;
                            beep_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (kd_q == 4'hB) begin
                        show_d = '0;
                        cnt_d  = '0;
                        beep_d = 1'b1;
                    end else if (kd_q == 4'hE) begin
                        if (cnt_q != 3'd0 && !ov_q) begin
                            od_d   = show_q;
                            ov_d   = 1'b1;
                            show_d = '0;
                            cnt_d  = '0;
                            beep_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_REL: begin
                if (kv_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == REL_LAST) begin
                    low_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; key level sync resets high
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            kv_q      <= 1'b1;
            kv_qq     <= 1'b1;
            kd_q      <= '0;
            low_cnt_q <= '0;
            show_q    <= '0;
            cnt_q     <= '0;
            beep_q    <= 1'b0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
        end else begin
            state_q   <= state_d;
            kv_q      <= bus.key_valid;
            kv_qq     <= kv_q;
            kd_q      <= bus.key_data;
            low_cnt_q <= low_cnt_d;
            show_q    <= show_d;
            cnt_q     <= cnt_d;
            beep_q    <= beep_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
        end
    end

    assign bus.show_data = show_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.beep_req  = beep_q;
    assign bus.err       = err_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios plus random key
// episodes, every cycle compared against a digit-queue model.
module tb_key_entry_ctrl;

    localparam int RC = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always #5 sys_clk = ~sys_clk;

    key_entry_ctrl_if bus ();

    key_entry_ctrl #(
        .RELEASE_CYC(RC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_beep = 0;
    int n_err  = 0;

    // reference model: entered digits oldest first, lockout tracking
    int          digits[$];
    logic        m_beep, m_err, m_ov;
    logic [23:0] m_od;
    logic        prev_v, armed, pend;
    logic [3:0]  pkey;
    int          lowcnt;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] packed_buf();
        logic [23:0] r;
        r = '0;
        foreach (digits[i]) r = (r << 4) | 24'(digits[i]);
        return r;
    endfunction

    task automatic model_reset();
        digits.delete();
        m_beep = 0;
        m_err  = 0;
        m_ov   = 0;
        m_od   = '0;
        prev_v = 1;
        armed  = 1;
        pend   = 0;
        pkey   = '0;
        lowcnt = 0;
    endtask

    task automatic apply_key(logic [3:0] k, logic ov_pre);
        int n;
        n = digits.size();
        if (k <= 4'h9) begin
            if (n < 6) begin digits.push_back(int'(k)); m_beep = 1; end
            else m_err = 1;
        end else if (k == 4'hA) begin
            if (n > 0) begin void'(digits.pop_back()); m_beep = 1; end
            else m_err = 1;
        end else if (k == 4'hB) begin
            digits.delete();
            m_beep = 1;
        end else if (k == 4'hE) begin
            if (n > 0 && !ov_pre) begin
                m_od = packed_buf();
                m_ov = 1;
                digits.delete();
                m_beep = 1;
            end else m_err = 1;
        end
    endtask

    task automatic model_step();
        logic v, rdy, ov_pre;
        logic [3:0] k;
        v      = bus.key_valid;
        k      = bus.key_data;
        rdy    = bus.out_ready;
        ov_pre = m_ov;
        m_beep = 0;
        m_err  = 0;
        if (pend) apply_key(pkey, ov_pre);
        if (ov_pre && rdy) m_ov = 0;
        pend = 0;
        if (armed) begin
            if (v && !prev_v) begin
                pend   = 1;
                pkey   = k;
                armed  = 0;
                lowcnt = 0;
            end
        end else if (v) begin
            lowcnt = 0;
        end else begin
            lowcnt++;
            if (lowcnt == RC) begin
                armed  = 1;
                lowcnt = 0;
            end
        end
        prev_v = v;
    endtask

    task automatic check_all();
        check("show", 32'(bus.show_data), 32'(packed_buf()));
        check("cnt", 32'(bus.digit_cnt), 32'(digits.size()));
        check("beep", 32'(bus.beep_req), 32'(m_beep));
        check("err", 32'(bus.err), 32'(m_err));
        check("ovalid", 32'(bus.out_valid), 32'(m_ov));
        check("odata", 32'(bus.out_data), 32'(m_od));
        check("excl", 32'(bus.beep_req & bus.err), 32'd0);
        n_beep += int'(bus.beep_req);
        n_err  += int'(bus.err);
    endtask

    task automatic tick(logic v, logic [3:0] k, logic rdy,
                        logic r = 1'b0);
        @(negedge sys_clk);
        bus.key_valid = v;
        bus.key_data  = k;
        bus.out_ready = rdy;
        if (r && !sys_rst) begin
            sys_rst = 1'b1;
            model_reset();
            #1;
            check("rst_show", 32'(bus.show_data), 32'd0);
            check("rst_cnt", 32'(bus.digit_cnt), 32'd0);
            check("rst_ov", 32'(bus.out_valid), 32'd0);
            check("rst_od", 32'(bus.out_data), 32'd0);
            check("rst_pulse", 32'({bus.beep_req, bus.err}), 32'd0);
        end else if (!r) begin
            sys_rst = 1'b0;
        end
        @(posedge sys_clk);
        if (!sys_rst) model_step();
        #1;
        check_all();
    endtask

    // rmode: 0 never ready, 1 always ready, 2 random ready
    function automatic logic pick_rdy(int rmode);
        if (rmode == 0) return 1'b0;
        if (rmode == 1) return 1'b1;
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic press(logic [3:0] k, int hold, int gap, int rmode);
        for (int i = 0; i < hold; i++)
            tick(1'b1, (i == 0) ? k : 4'($urandom), pick_rdy(rmode));
        for (int i = 0; i < gap; i++)
            tick(1'b0, 4'($urandom), pick_rdy(rmode));
    endtask

    initial begin
        int b0, e0;
        bus.key_valid = 1'b0;
        bus.key_data  = 4'h0;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        check("init_show", 32'(bus.show_data), 32'd0);
        check("init_ov", 32'(bus.out_valid), 32'd0);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'h0, 1'b0);

        // three digits with long holds and gaps
        b0 = n_beep;
        press(4'h1, 10, 10, 0);
        press(4'h2, 10, 10, 0);
        press(4'h3, 10, 10, 0);
        check("d123_show", 32'(bus.show_data), 32'h000123);
        check("d123_cnt", 32'(bus.digit_cnt), 32'd3);
        check("d123_beeps", 32'(n_beep - b0), 32'd3);

        // overflow on seventh digit, then backspace
        press(4'hB, 2, 5, 0);
        b0 = n_beep;
        e0 = n_err;
        for (int d = 1; d <= 7; d++) press(4'(d), 3, 5, 0);
        check("full_show", 32'(bus.show_data), 32'h123456);
        check("full_cnt", 32'(bus.digit_cnt), 32'd6);
        check("full_beeps", 32'(n_beep - b0), 32'd6);
        check("full_errs", 32'(n_err - e0), 32'd1);
        press(4'hA, 3, 5, 0);
        check("bs_show", 32'(bus.show_data), 32'h012345);
        check("bs_cnt", 32'(bus.digit_cnt), 32'd5);

        // commit with stalled consumer, rejected second enter
        press(4'hB, 2, 5, 0);
        press(4'h4, 2, 5, 0);
        press(4'h2, 2, 5, 0);
        press(4'hE, 2, 5, 0);
        check("ent_ov", 32'(bus.out_valid), 32'd1);
        check("ent_od", 32'(bus.out_data), 32'h000042);
        check("ent_show", 32'(bus.show_data), 32'd0);
        press(4'h9, 2, 5, 0);
        e0 = n_err;
        press(4'hE, 2, 5, 0);
        check("ent2_show", 32'(bus.show_data), 32'h000009);
        check("ent2_err", 32'(n_err - e0), 32'd1);
        check("ent2_od", 32'(bus.out_data), 32'h000042);
        tick(1'b0, 4'h0, 1'b1);
        check("xfer_ov", 32'(bus.out_valid), 32'd0);
        tick(1'b0, 4'h0, 1'b0);

        // bounce, then short-gap press ignored, full-gap press taken
        press(4'hB, 2, 5, 0);
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b0, 4'h3, 1'b0);
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b0, 4'h3, 1'b0);
        press(4'h3, 5, RC - 1, 0);
        press(4'h7, 3, RC, 0);
        press(4'h8, 3, RC, 0);
        check("bnc_show", 32'(bus.show_data), 32'h000038);
        check("bnc_cnt", 32'(bus.digit_cnt), 32'd2);

        // silent keys and clear on empty buffer
        press(4'hB, 2, 5, 0);
        b0 = n_beep;
        e0 = n_err;
        press(4'hC, 2, 5, 0);
        press(4'hD, 2, 5, 0);
        press(4'hF, 2, 5, 0);
        check("silent_beep", 32'(n_beep - b0), 32'd0);
        check("silent_err", 32'(n_err - e0), 32'd0);
        press(4'hB, 2, 5, 0);
        check("clr_beep", 32'(n_beep - b0), 32'd1);
        check("clr_show", 32'(bus.show_data), 32'd0);

        // key held through reset release
        b0 = n_beep;
        for (int i = 0; i < 3; i++) tick(1'b1, 4'h5, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'h5, 1'b0);
        check("held_beep", 32'(n_beep - b0), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, 4'h5, 1'b0);
        press(4'h5, 3, 5, 0);
        check("rel_show", 32'(bus.show_data), 32'h000005);
        check("rel_beep", 32'(n_beep - b0), 32'd1);

        // reset while a committed value is pending
        press(4'hE, 2, 5, 0);
        check("prst_ov", 32'(bus.out_valid), 32'd1);
        tick(1'b1, 4'h6, 1'b0, 1'b1);
        tick(1'b1, 4'h6, 1'b1, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'h0, 1'b0);

        // random episodes
        for (int ep = 0; ep < 300; ep++) begin
            logic [3:0] k;
            if ($urandom_range(0, 99) < 3) begin
                tick(1'($urandom), 4'($urandom), 1'b0, 1'b1);
                tick(1'b0, 4'($urandom), 1'b0, 1'b1);
            end
            if ($urandom_range(0, 1) == 0) k = 4'($urandom_range(0, 9));
            else k = 4'($urandom_range(0, 15));
            press(k, $urandom_range(1, 8), $urandom_range(1, 7),
                  $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
